sklansky_sub_pipe: RTL
======================

SKLANSKY_SUB_PIPE -- requirements
Module: sklansky_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 4, operand width; SHALL be a power of two, 2..32.
REQ-002 Port clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port A  input  WIDTH  minuend.
REQ-005 Port B  input  WIDTH  subtrahend.
REQ-006 Port Bin  input  1  borrow-in.
REQ-007 Port in_valid  input  1  A/B/Bin valid this cycle.
REQ-008 Port in_ready  output  1  block accepts the operand set this cycle.
REQ-009 Port Diff  output  WIDTH  result (A - B - Bin) mod 2^WIDTH.
REQ-010 Port Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).
REQ-011 Port out_valid  output  1  Diff/Bout valid.
REQ-012 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-013 Port Count  output  8  number of results delivered, modulo 256.

Function
REQ-014 Arithmetic SHALL be A + ~B + ~Bin on a Sklansky parallel-prefix carry network; Bout SHALL be the inverse of the prefix carry-out.
REQ-015 Stage 1 SHALL register the per-bit generate/propagate values and the first ceil(log2(WIDTH)/2) prefix levels; stage 2 SHALL register the remaining levels, Diff and Bout.
REQ-016 Latency SHALL be exactly 2 cycles from the handshake (in_valid & in_ready) to out_valid when out_ready stays high.
REQ-017 Throughput SHALL be one operation per cycle with out_ready held high.
REQ-018 Stage 2 SHALL load when it is empty or out_ready=1; stage 1 SHALL load when it is empty or stage 2 loads.
REQ-019 in_ready SHALL be high when stage 1 is empty or stage 2 loads in that cycle; it SHALL be combinational with no path from in_valid.
REQ-020 While out_valid=1 and out_ready=0, Diff, Bout and out_valid SHALL hold stable.
REQ-021 Bubbles SHALL collapse: an empty stage 2 SHALL accept stage 1 contents regardless of out_ready.
REQ-022 Count SHALL increment on each out_valid & out_ready cycle and wrap from 255 to 0.
REQ-023 Operand values presented without in_valid SHALL have no effect on state.

Reset
REQ-024 While rst_n=0: both stage valid flags=0, out_valid=0, Diff=0, Bout=0, Count=0, Ovf=0 (if present); in_ready SHALL read 1 one cycle after rst_n deasserts.
REQ-025 Assertion of rst_n mid-operation SHALL discard all in-flight operations; no stale result SHALL appear after reset release.

Configuration
REQ-026 Macro SKLANSKY_SUB_OVF_EN: when defined, the block SHALL add output Ovf (1 bit), two's-complement overflow of A - B - Bin, pipelined alongside Diff with the same hold rules.
REQ-027 Without SKLANSKY_SUB_OVF_EN, port Ovf and its registers SHALL be absent.

Structure
REQ-028 Shared package sklansky_pkg SHALL hold the prefix-level count function (clog2), the generate/propagate pair typedef, and the constant COUNT_W=8.
REQ-029 Sub-module sklansky_prefix SHALL implement the combinational prefix network for a level range, instantiated once per stage.

Verification
REQ-030 A=1101 B=1011 Bin=0 -> 2 cycles later Diff=0010 Bout=0 (Ovf=0).
REQ-031 A=0110 B=1001 Bin=0 -> Diff=1101 Bout=1 (Ovf=1); A=0000 B=0000 Bin=1 -> Diff=1111 Bout=1.
REQ-032 Six back-to-back operands with out_ready=1 -> six results on consecutive cycles, in order; Count=6.
REQ-033 out_ready=0 for 3 cycles with a stream applied -> in_ready drops after two accepted operations; held Diff is unchanged; no loss or duplication after release.
REQ-034 rst_n pulsed low with two operations in flight -> out_valid=0, Count=0, and no result emerges after release.
REQ-035 Random 10k operations with random out_ready, WIDTH=4 and 16 -> every {Bout,Diff} matches the reference model; Count equals deliveries mod 256.

Source files
------------

// File: rtl/sklansky_pkg.sv
// Shared definitions for the pipelined Sklansky subtractor: generate/propagate
// pair, prefix-level count helper and the delivered-result counter width.
package sklansky_pkg;

    localparam int COUNT_W = 8;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of prefix levels needed to span n bits (ceil(log2(n))).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sklansky_prefix.sv
// Combinational Sklansky prefix levels LO..HI-1 over WIDTH generate/propagate
// pairs; an empty range (LO == HI) is a pass-through.
module sklansky_prefix
    import sklansky_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LO    = 0,
    parameter int HI    = 1
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);

    // NOTE: every variable in a combinational block is fully assigned before
    // any conditional update, so no path leaves it holding a value (no latch).
    always_comb begin
        gp_t [WIDTH-1:0] cur;
        gp_t [WIDTH-1:0] nxt;
        int              j;
        cur = gp_in;
        nxt = gp_in;
        j   = 0;
        for (int l = LO; l < HI; l++) begin
            nxt = cur;
            for (int i = 0; i < WIDTH; i++) begin
                // Upper half of each 2^(l+1) block combines with the top bit
                // of the lower half.
                if (i[l]) begin
                    j        = ((i >> l) << l) - 1;
                    nxt[i].g = cur[i].g | (cur[i].p & cur[j].g);
                    nxt[i].p = cur[i].p & cur[j].p;
                end
            end
            cur = nxt;
        end
        gp_out = cur;
    end

endmodule

// File: rtl/sklansky_sub_pipe.sv
// Two-stage pipelined subtractor A - B - Bin on a Sklansky prefix network with
// valid/ready flow control. Optional Ovf output enabled by SKLANSKY_SUB_OVF_EN.
module sklansky_sub_pipe
    import sklansky_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               Bin,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   Diff,
    output logic               Bout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] Count
`ifdef SKLANSKY_SUB_OVF_EN
    ,
    output logic               Ovf
`endif
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int L1     = (LEVELS + 1) / 2;

    logic             v1;
    logic             v2;
    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] hp0;
    gp_t  [WIDTH-1:0] gp0;
    gp_t  [WIDTH-1:0] gp1;
    gp_t  [WIDTH-1:0] s1_gp;
    logic [WIDTH-1:0] s1_hp;
    logic             s1_cin;
    gp_t  [WIDTH-1:0] gp2;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_next;
    logic             bout_next;
    logic [WIDTH-1:0] unused_p;

    assign s2_load   = !v2 || out_ready;
    assign s1_load   = !v1 || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = v2;

    // Subtraction as A + ~B + ~Bin: the borrow-in becomes carry-in and is
    // folded into bit 0's generate so the prefix yields true carries.
    assign hp0 = A ^ ~B;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            gp0[i].p = hp0[i];
            gp0[i].g = A[i] & ~B[i];
        end
        gp0[0].g = gp0[0].g | (hp0[0] & ~Bin);
    end

    sklansky_prefix #(.WIDTH(WIDTH), .LO(0), .HI(L1)) u_prefix_s1 (
        .gp_in  (gp0),
        .gp_out (gp1)
    );

    sklansky_prefix #(.WIDTH(WIDTH), .LO(L1), .HI(LEVELS)) u_prefix_s2 (
        .gp_in  (s1_gp),
        .gp_out (gp2)
    );

    always_comb begin
        carry[0] = s1_cin;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = gp2[i-1].g;
        end
        for (int i = 0; i < WIDTH; i++) begin
            unused_p[i] = gp2[i].p;
        end
    end

    assign diff_next = s1_hp ^ carry;
    assign bout_next = ~gp2[WIDTH-1].g;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (s1_load) v1 <= in_valid;
            if (s2_load) v2 <= v1;
        end
    end

    // NOTE: datapath registers are reset too so Diff/Bout read 0 during reset
    // and nothing from before reset can reappear afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_gp  <= '0;
            s1_hp  <= '0;
            s1_cin <= 1'b0;
        end else if (s1_load && in_valid) begin
            s1_gp  <= gp1;
            s1_hp  <= hp0;
            s1_cin <= ~Bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Diff <= '0;
            Bout <= 1'b0;
        end else if (s2_load && v1) begin
            Diff <= diff_next;
            Bout <= bout_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Count <= '0;
        end else if (v2 && out_ready) begin
            Count <= Count + 1'b1;
        end
    end

`ifdef SKLANSKY_SUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ovf <= 1'b0;
        end else if (s2_load && v1) begin
            Ovf <= carry[WIDTH-1] ^ gp2[WIDTH-1].g;
        end
    end
`endif

endmodule
